// File: rtl/alu_sequencer_if.sv
// Command and response handshake bundle between the datapath controller and alu_sequencer.
// The slave modport is the sequencer side; the master modport is the command source / response sink.
interface alu_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] cmd_opcode;
  logic       cmd_acc;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_resultado;
  logic       rsp_zero;
  logic [7:0] rsp_count;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_acc, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_resultado, rsp_zero, rsp_count
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_acc, rsp_ready,
    output cmd_ready, rsp_valid, rsp_resultado, rsp_zero, rsp_count
  );
endinterface

// File: rtl/alu_sequencer.sv
// Queues ALU commands, drives the combinational ALU one command at a time, captures
// the result after SETTLE cycles and returns it over a valid/ready response channel.
module alu_sequencer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  alu_sequencer_if.slave      bus,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [3:0]          alu_opcode,
  input  logic [7:0]          alu_resultado,
  input  logic                alu_zero
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam int EW = 21;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DRIVE   = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;

  logic [EW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          ready_r;
  logic          push_s;
  logic          pop_s;
  logic [EW-1:0] head_s;

  logic [1:0]    state_r;
  logic [SW-1:0] settle_r;
  logic [7:0]    acc_r;
  logic [7:0]    alu_a_r;
  logic [7:0]    alu_b_r;
  logic [3:0]    alu_opcode_r;
  logic          rsp_valid_r;
  logic [7:0]    rsp_resultado_r;
  logic          rsp_zero_r;
  logic [7:0]    rsp_count_r;

  assign push_s = bus.cmd_valid & ready_r;
  assign pop_s  = (state_r == IDLE) & (count_r != {CW{1'b0}});
  assign head_s = mem_r[rd_ptr_r];

  // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Entry storage {acc, opcode, b, a}; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {bus.cmd_acc, bus.cmd_opcode, bus.cmd_b, bus.cmd_a};
    end
  end

  // Pointers, occupancy and the registered not-full flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      ready_r  <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      ready_r <= (count_nxt_s != CW'(DEPTH));
    end
  end

  // Sequencing FSM: the accumulator is sampled at pop time so back-to-back chains see the latest result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      settle_r        <= {SW{1'b0}};
      acc_r           <= 8'h00;
      alu_a_r         <= 8'h00;
      alu_b_r         <= 8'h00;
      alu_opcode_r    <= 4'h0;
      rsp_valid_r     <= 1'b0;
      rsp_resultado_r <= 8'h00;
      rsp_zero_r      <= 1'b0;
      rsp_count_r     <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            alu_a_r      <= head_s[20] ? acc_r : head_s[7:0];
            alu_b_r      <= head_s[15:8];
            alu_opcode_r <= head_s[19:16];
            settle_r     <= SW'(SETTLE);
            state_r      <= DRIVE;
          end
        end
        DRIVE: begin
          if (settle_r == SW'(1)) begin
            rsp_resultado_r <= alu_resultado;
            rsp_zero_r      <= alu_zero;
            acc_r           <= alu_resultado;
            rsp_valid_r     <= 1'b1;
            state_r         <= RESPOND;
          end else begin
            settle_r <= settle_r - SW'(1);
          end
        end
        RESPOND: begin
          if (rsp_valid_r && bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_count_r <= rsp_count_r + 8'd1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign alu_a             = alu_a_r;
  assign alu_b             = alu_b_r;
  assign alu_opcode        = alu_opcode_r;
  assign bus.cmd_ready     = ready_r;
  assign bus.rsp_valid     = rsp_valid_r;
  assign bus.rsp_resultado = rsp_resultado_r;
  assign bus.rsp_zero      = rsp_zero_r;
  assign bus.rsp_count     = rsp_count_r;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-side controller for the 8-bit ALU: accepts operation commands (a, b, opcode) over a valid/ready interface and buffers them in a small FIFO.
- Drives the ALU operand/opcode inputs one command at a time, waits a fixed settle time, then captures resultado/zero.
- Returns each captured result over a valid/ready response interface.
- Sits between the register/datapath control logic and the combinational alu instance, which it drives directly.

Parameters:
- DEPTH, 4, command FIFO depth in entries; power of two, ≥2.
- SETTLE, 1, cycles ALU inputs are held before result capture; ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at rising edge.
- cmd_a  in  8  operand a.
- cmd_b  in  8  operand b.
- cmd_opcode  in  4  ALU selection, passed through unmodified.
- cmd_acc  in  1  1 = use accumulator (last captured resultado) as operand a instead of cmd_a.
- alu_a  out  8  to ALU a.
- alu_b  out  8  to ALU b.
- alu_opcode  out  4  to ALU opcode.
- alu_resultado  in  8  from ALU resultado.
- alu_zero  in  1  from ALU zero.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at rising edge.
- rsp_resultado  out  8  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_count  out  8  number of completed response handshakes, modulo 256.

Behaviour:
- Reset (async, immediate):
  - FIFO emptied; state IDLE.
  - alu_a, alu_b, alu_opcode, rsp_resultado, accumulator = 0.
  - rsp_zero = 0; rsp_valid = 0; rsp_count = 0.
  - cmd_ready = 1 after reset deasserts.
  - Reset mid-operation discards all queued/in-flight commands; no response is produced for them.
- FIFO:
  - Each entry stores {acc, opcode, b, a}.
  - cmd_ready = !full, registered-state based; no combinational dependence on the pop.
  - Push and pop in the same cycle are legal: count unchanged.
  - A push when full is impossible (ready low); cmd_valid while not ready is ignored.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, DRIVE, RESPOND.
  - IDLE: if FIFO non-empty, pop the head and register the ALU inputs:
    - alu_a = (acc ? accumulator : a); alu_b = b; alu_opcode = opcode.
    - Load settle counter = SETTLE; go to DRIVE.
    - If empty, stay; ALU inputs hold their last values.
  - DRIVE: ALU inputs held constant; counter decrements each cycle.
    - On the cycle counter == 1: capture rsp_resultado = alu_resultado, rsp_zero = alu_zero, accumulator = alu_resultado.
    - Set rsp_valid = 1; go to RESPOND.
  - RESPOND: rsp_valid, rsp_resultado and rsp_zero are held stable until the handshake.
    - On handshake: rsp_valid = 0, rsp_count += 1 (wraps 255→0), go to IDLE.
    - rsp_valid is never withdrawn without a handshake except by reset.
- Latency:
  - Command pushed at edge N (FIFO previously empty, state IDLE) → popped at edge N+1 → rsp_valid high after edge N+1+SETTLE.
  - With rsp_ready tied high, throughput is 1 command per SETTLE+2 cycles.
- Ordering: responses are in strict command order; exactly one response per accepted command.
- Accumulator semantics:
  - The accumulator is the last captured result at the time the command is popped, not when it is pushed.
  - A cmd_acc command immediately following another therefore chains correctly.

Test Plan:
- All tests use a bench ALU model: resultado = a + b (8-bit wrap), zero = (resultado == 0).
- Single command: push a=8'h0A, b=8'h02, op=4'h1, acc=0, rsp_ready=1 → rsp_valid high 2 cycles after accept; rsp_resultado=8'h0C, rsp_zero=0; alu_opcode=4'h1 during DRIVE; rsp_count=1.
- Wrap/zero: push a=8'hF6, b=8'h0A → rsp_resultado=8'h00, rsp_zero=1.
- Accumulate chain: push (a=8'h05, b=8'h03), then (acc=1, a=8'hFF, b=8'h02) back-to-back → responses 8'h08 then 8'h0A, in order.
- Backpressure/full (DEPTH=4, rsp_ready=0):
  - Push 6 commands with cmd_valid held: 1 is popped into DRIVE, 4 fill the FIFO, cmd_ready then drops, and the 6th is held.
  - rsp_valid and rsp_resultado stay stable for 10 cycles.
  - Then rsp_ready=1 → 6 responses in order; final rsp_count=6.
- Simultaneous push/pop: with FIFO holding 1 entry in IDLE, assert cmd_valid that same cycle → count stays 1, cmd_ready stays 1, no command lost or duplicated.
- Reset mid-operation: assert rst while in DRIVE with 2 queued → rsp_valid=0 and rsp_count=0 immediately (asynchronously); after release, no stale responses appear and a new command completes normally.
